// File: rtl/cmp_mask_packer.sv
// Packs per-element compare results into a one-bit-per-element mask for vd write-back.
// Optional macro CMP_MASK_TAIL_AGNOSTIC_EN: tail bits (index >= vl) are filled with ones at start.
module cmp_mask_packer #(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  ELEM_MAX   = 32,
    localparam int unsigned VL_W       = $clog2(ELEM_MAX + 1)
) (
    input  logic                  module_clk_i,
    input  logic                  module_rst_ni,
    input  logic                  start_i,
    input  logic [VL_W-1:0]       vl_i,
    input  logic                  vm_i,
    input  logic [ELEM_MAX-1:0]   v0_i,
    input  logic [ELEM_MAX-1:0]   old_mask_i,
    input  logic                  res_valid_i,
    input  logic [DATA_WIDTH-1:0] res_i,
    output logic                  res_ready_o,
    output logic [VL_W-1:0]       elem_idx_o,
    output logic                  busy_o,
    output logic                  mask_valid_o,
    output logic [ELEM_MAX-1:0]   mask_o,
    input  logic                  mask_ready_i,
    output logic                  err_o
);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e              state_q, state_d;
    logic [ELEM_MAX-1:0] mask_q, mask_d;
    logic [ELEM_MAX-1:0] v0_q, v0_d;
    logic [ELEM_MAX-1:0] old_q, old_d;
    logic [VL_W-1:0]     idx_q, idx_d;
    logic [VL_W-1:0]     vl_q, vl_d;
    logic                vm_q, vm_d;
    logic                err_q, err_d;

    logic [VL_W-1:0]     vl_clamp;
    logic                start_ok;
    logic                accept;
    logic                last;
    logic                unused_res;

    // Only the element flag matters; upper bits may carry min/max passthrough data.
    assign unused_res = ^res_i[DATA_WIDTH-1:1];

    assign vl_clamp = (vl_i > VL_W'(ELEM_MAX)) ? VL_W'(ELEM_MAX) : vl_i;
    assign start_ok = (state_q == StIdle) && start_i;
    assign accept   = (state_q == StCollect) && res_valid_i;
    assign last     = accept && (idx_q == vl_q - VL_W'(1));

    always_ff @(posedge module_clk_i or negedge module_rst_ni) begin
        if (!module_rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (vl_clamp == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                if (last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (mask_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        res_ready_o  = (state_q == StCollect);
        busy_o       = (state_q != StIdle);
        mask_valid_o = (state_q == StDone);
        mask_o       = (state_q == StDone) ? mask_q : '0;
        elem_idx_o   = (state_q == StCollect) ? idx_q : '0;
        err_o        = err_q;
    end

    always_comb begin
        mask_d = mask_q;
        idx_d  = idx_q;
        vl_d   = vl_q;
        vm_d   = vm_q;
        v0_d   = v0_q;
        old_d  = old_q;
        err_d  = err_q;

        if (start_ok) begin
            vl_d  = vl_clamp;
            vm_d  = vm_i;
            v0_d  = v0_i;
            old_d = old_mask_i;
            idx_d = '0;
`ifdef CMP_MASK_TAIL_AGNOSTIC_EN
            // vl == 0 writes nothing, so the old value passes through untouched.
            for (int unsigned i = 0; i < ELEM_MAX; i++) begin
                mask_d[i] = ((vl_clamp != '0) && (VL_W'(i) >= vl_clamp)) ? 1'b1 : old_mask_i[i];
            end
`else
            mask_d = old_mask_i;
`endif
        end

        if (accept) begin
            for (int unsigned i = 0; i < ELEM_MAX; i++) begin
                if (VL_W'(i) == idx_q) begin
                    mask_d[i] = (vm_q || v0_q[i]) ? res_i[0] : old_q[i];
                end
            end
            idx_d = idx_q + VL_W'(1);
        end

        if ((start_i && (state_q != StIdle)) || (res_valid_i && (state_q != StCollect))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge module_clk_i or negedge module_rst_ni) begin
        if (!module_rst_ni) begin
            mask_q <= '0;
            idx_q  <= '0;
            vl_q   <= '0;
            vm_q   <= 1'b0;
            v0_q   <= '0;
            old_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            idx_q  <= idx_d;
            vl_q   <= vl_d;
            vm_q   <= vm_d;
            v0_q   <= v0_d;
            old_q  <= old_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_cmp_mask_packer.sv
// Scoreboard bench for cmp_mask_packer: directed ops push expected masks, a monitor pops on handshake.
module tb_cmp_mask_packer;

    localparam int DW = 32;
    localparam int EM = 32;
    localparam int VW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [VW-1:0] vl_i;
    logic          vm_i;
    logic [EM-1:0] v0_i;
    logic [EM-1:0] old_mask_i;
    logic          res_valid_i;
    logic [DW-1:0] res_i;
    logic          res_ready_o;
    logic [VW-1:0] elem_idx_o;
    logic          busy_o;
    logic          mask_valid_o;
    logic [EM-1:0] mask_o;
    logic          mask_ready_i;
    logic          err_o;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [EM-1:0] exp_q[$];
    logic [EM-1:0] mon_exp;

    cmp_mask_packer #(.DATA_WIDTH(DW), .ELEM_MAX(EM)) dut (
        .module_clk_i (clk),
        .module_rst_ni(rst_n),
        .start_i      (start_i),
        .vl_i         (vl_i),
        .vm_i         (vm_i),
        .v0_i         (v0_i),
        .old_mask_i   (old_mask_i),
        .res_valid_i  (res_valid_i),
        .res_i        (res_i),
        .res_ready_o  (res_ready_o),
        .elem_idx_o   (elem_idx_o),
        .busy_o       (busy_o),
        .mask_valid_o (mask_valid_o),
        .mask_o       (mask_o),
        .mask_ready_i (mask_ready_i),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input logic [VW-1:0] vl, input logic vm, input logic [EM-1:0] v0,
                            input logic [EM-1:0] old);
        start_i    = 1'b1;
        vl_i       = vl;
        vm_i       = vm;
        v0_i       = v0;
        old_mask_i = old;
        tick();
        start_i    = 1'b0;
        // Scramble capture-only inputs so any late sampling shows up.
        vl_i       = VW'($urandom_range(0, 63));
        vm_i       = 1'($urandom());
        v0_i       = $urandom();
        old_mask_i = $urandom();
    endtask

    task automatic send(input logic b);
        logic [DW-1:0] r;
        r           = $urandom();
        r[0]        = b;
        res_valid_i = 1'b1;
        res_i       = r;
        tick();
        res_valid_i = 1'b0;
    endtask

    task automatic accept_mask();
        mask_ready_i = 1'b1;
        tick();
        mask_ready_i = 1'b0;
    endtask

    // Monitor: the write-back handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && mask_valid_o && mask_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_mask: got 0x%0h with no expected entry", mask_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("mask_o", 64'(mask_o), 64'(mon_exp));
            end
        end
    end

    initial begin
        logic [7:0] t1_bits;
        rst_n        = 1'b0;
        start_i      = 1'b0;
        vl_i         = '0;
        vm_i         = 1'b0;
        v0_i         = '0;
        old_mask_i   = '0;
        res_valid_i  = 1'b0;
        res_i        = '0;
        mask_ready_i = 1'b0;
        t1_bits      = 8'b0100_1101;

        #12;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(mask_valid_o), 64'd0);
        check("rst_mask", 64'(mask_o), 64'd0);
        check("rst_ready", 64'(res_ready_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: vl=8 unmasked, results 1,0,1,1,0,0,1,0 back to back.
`ifdef CMP_MASK_TAIL_AGNOSTIC_EN
        exp_q.push_back(32'hFFFF_FF4D);
`else
        exp_q.push_back(32'hFFFF_004D);
`endif
        start_op(6'd8, 1'b1, 32'h0, 32'hFFFF_0000);
        check("t1_busy", 64'(busy_o), 64'd1);
        check("t1_ready", 64'(res_ready_o), 64'd1);
        check("t1_idx0", 64'(elem_idx_o), 64'd0);
        for (int i = 0; i < 7; i++) send(t1_bits[i]);
        check("t1_idx7", 64'(elem_idx_o), 64'd7);
        check("t1_not_yet_valid", 64'(mask_valid_o), 64'd0);
        send(t1_bits[7]);
        check("t1_valid_after_last", 64'(mask_valid_o), 64'd1);
        check("t1_ready_low_done", 64'(res_ready_o), 64'd0);
        accept_mask();
        check("t1_idle", 64'(busy_o), 64'd0);
        check("t1_valid_drop", 64'(mask_valid_o), 64'd0);

        // 2: v0-masked, elements 1 and 3 keep old bits.
`ifdef CMP_MASK_TAIL_AGNOSTIC_EN
        exp_q.push_back(32'hFFFF_FFFF);
`else
        exp_q.push_back(32'h0000_000F);
`endif
        start_op(6'd4, 1'b0, 32'h5, 32'hA);
        send(1'b1);
        send(1'b1);
        check("t2_idx2", 64'(elem_idx_o), 64'd2);
        send(1'b1);
        send(1'b1);
        check("t2_valid", 64'(mask_valid_o), 64'd1);
        accept_mask();

        // 3: vl=0 goes straight to DONE with the old value.
        exp_q.push_back(32'h1234_5678);
        start_op(6'd0, 1'b1, 32'h0, 32'h1234_5678);
        check("t3_valid", 64'(mask_valid_o), 64'd1);
        check("t3_no_ready", 64'(res_ready_o), 64'd0);
        accept_mask();
        check("t3_idle", 64'(busy_o), 64'd0);

        // 4: gapped results, then write-back stalls for 5 cycles.
`ifdef CMP_MASK_TAIL_AGNOSTIC_EN
        exp_q.push_back(32'hFFFF_FFFB);
`else
        exp_q.push_back(32'h0000_0003);
`endif
        start_op(6'd3, 1'b1, 32'h0, 32'h0);
        send(1'b1);
        tick();
        check("t4_idx_hold1", 64'(elem_idx_o), 64'd1);
        send(1'b1);
        tick();
        check("t4_idx_hold2", 64'(elem_idx_o), 64'd2);
        send(1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_valid", 64'(mask_valid_o), 64'd1);
`ifdef CMP_MASK_TAIL_AGNOSTIC_EN
            check("t4_stall_mask", 64'(mask_o), 64'hFFFF_FFFB);
`else
            check("t4_stall_mask", 64'(mask_o), 64'h0000_0003);
`endif
            tick();
        end
        accept_mask();
        check("t4_idle", 64'(busy_o), 64'd0);

        // 5: result in IDLE is an error and is ignored.
        check("t5_err_clear", 64'(err_o), 64'd0);
        res_valid_i = 1'b1;
        tick();
        res_valid_i = 1'b0;
        check("t5_err_set", 64'(err_o), 64'd1);
        check("t5_still_idle", 64'(busy_o), 64'd0);
        tick();
        check("t5_err_sticky", 64'(err_o), 64'd1);

        // 6: reset mid-op after 2 of 6 elements.
        start_op(6'd6, 1'b1, 32'h0, 32'hFFFF_FFFF);
        send(1'b0);
        send(1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_busy", 64'(busy_o), 64'd0);
        check("t6_async_ready", 64'(res_ready_o), 64'd0);
        check("t6_async_idx", 64'(elem_idx_o), 64'd0);
        check("t6_async_err", 64'(err_o), 64'd0);
        check("t6_async_valid", 64'(mask_valid_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
`ifdef CMP_MASK_TAIL_AGNOSTIC_EN
        exp_q.push_back(32'hFFFF_FFFF);
`else
        exp_q.push_back(32'h0000_0001);
`endif
        start_op(6'd1, 1'b1, 32'h0, 32'h0);
        send(1'b1);
        check("t6_valid", 64'(mask_valid_o), 64'd1);
        accept_mask();

        // 7: start during COLLECT and during the DONE handshake are both ignored.
        check("t7_err_clear", 64'(err_o), 64'd0);
`ifdef CMP_MASK_TAIL_AGNOSTIC_EN
        exp_q.push_back(32'hFFFF_FFFF);
`else
        exp_q.push_back(32'h0000_0003);
`endif
        start_op(6'd2, 1'b1, 32'h0, 32'h0);
        send(1'b1);
        start_i    = 1'b1;
        vl_i       = 6'd5;
        old_mask_i = 32'hFFFF_0000;
        tick();
        start_i = 1'b0;
        check("t7_err_busy_start", 64'(err_o), 64'd1);
        check("t7_idx_kept", 64'(elem_idx_o), 64'd1);
        send(1'b1);
        start_i      = 1'b1;
        vl_i         = 6'd3;
        mask_ready_i = 1'b1;
        tick();
        start_i      = 1'b0;
        mask_ready_i = 1'b0;
        check("t7_start_at_handshake_ignored", 64'(busy_o), 64'd0);
        check("t7_err_sticky", 64'(err_o), 64'd1);

        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmp_mask_packer.md
Name: cmp_mask_packer

Overview:
- Sits directly downstream of the vector compare unit.
- Collects the per-element compare results (all-ones/all-zeros words for VMSEQ/VMSNE/VMSLT/VMSLE/VMSGT and their unsigned forms), one element per handshake.
- Packs them into a one-bit-per-element mask register value, applying v0 masking and tail policy.
- Presents the finished mask to the register-file write-back port with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, width of the compare result word.
- ELEM_MAX, 32, maximum elements per instruction (VLMAX) and width of the packed mask.
- VL_W, $clog2(ELEM_MAX+1), width of the vl and index fields (derived, not overridden).

Ports:
- module_clk_i  in  1  block clock
- module_rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  begin a new mask instruction; sampled only in IDLE
- vl_i  in  VL_W  active vector length, captured at start
- vm_i  in  1  1 = unmasked op; 0 = v0 masking active; captured at start
- v0_i  in  ELEM_MAX  v0 mask bits, captured at start
- old_mask_i  in  ELEM_MAX  previous vd contents (undisturbed source), captured at start
- res_valid_i  in  1  compare result valid
- res_i  in  DATA_WIDTH  compare result word; bit 0 is the element flag
- res_ready_o  out  1  packer accepts a result this cycle
- elem_idx_o  out  VL_W  index of the next element expected
- busy_o  out  1  state != IDLE
- mask_valid_o  out  1  packed mask available
- mask_o  out  ELEM_MAX  packed mask value
- mask_ready_i  in  1  write-back accepts the mask
- err_o  out  1  sticky protocol error flag

Behaviour:
- Reset (module_rst_ni low, asynchronous): state = IDLE, all outputs 0, internal mask/idx/vl/v0/old registers 0.
- States: IDLE, COLLECT, DONE.
- IDLE, start_i = 1:
  - Capture vl (clamped to ELEM_MAX if vl_i > ELEM_MAX), vm, v0 and old_mask.
  - Initialise mask_reg = old_mask_i and idx = 0.
  - Go to COLLECT if vl != 0. If vl == 0, go directly to DONE with mask_reg = old_mask_i.
- COLLECT:
  - res_ready_o = 1.
  - On each res_valid_i & res_ready_o: mask_reg[idx] = res_i[0] if (vm | v0[idx]), else it keeps old_mask[idx] (mask-undisturbed). Then idx increments.
  - The handshake that accepts idx == vl-1 moves the FSM to DONE on the next edge.
  - Only bit 0 of res_i is used. Upper bits are don't-care for min/max passthrough words.
- DONE:
  - mask_valid_o = 1 and mask_o = mask_reg, held stable until mask_ready_i.
  - Handshake moves the FSM to IDLE. mask_valid_o drops the following cycle.
- Tail bits (index >= vl) follow the tail policy under Optional Feature. The default is undisturbed (old_mask).
- Latency: first result can be accepted the cycle after start. mask_valid_o rises the cycle after the last accepted result. Throughput is 1 element/cycle.
- mask_o outside DONE: driven to 0.
- elem_idx_o = idx in COLLECT, 0 otherwise.
- Protocol errors:
  - start_i while busy_o: ignored, err_o set.
  - res_valid_i outside COLLECT: ignored, err_o set.
  - err_o is cleared only by reset.
- A start_i in the same cycle as the DONE→IDLE handshake counts as busy (ignored, error).
- Reset mid-operation: immediate return to IDLE, partial mask discarded, no mask_valid_o.
- idx never wraps: it stops at vl, and the index counter is VL_W bits wide so ELEM_MAX fits.

Optional Feature:
- Macro: CMP_MASK_TAIL_AGNOSTIC_EN.
- Defined: at start, tail bits (index >= vl) of mask_reg are set to 1 (mask-agnostic all-ones fill). Masked-off body elements still use old_mask.
- Undefined: tail bits keep old_mask_i (tail-undisturbed).
- Body behaviour is identical in both builds.

Test Plan:
1. ELEM_MAX=32, vl=8, vm=1, old=0xFFFF0000; results bit0 = 1,0,1,1,0,0,1,0 on consecutive cycles.
   → mask_o = 0xFFFF004D with valid one cycle after the 8th handshake. The tail variant gives 0xFFFFFF4D.
2. vl=4, vm=0, v0=0x5, old=0x0000000A, all results 1.
   → mask_o = 0x0000000F (elements 1 and 3 from old). Tail-agnostic gives 0xFFFFFFFF.
3. vl=0, old=0x12345678.
   → DONE the cycle after start, mask_o = 0x12345678, no res_ready_o ever asserted.
4. vl=3 with res_valid_i toggling every other cycle and mask_ready_i held low 5 cycles.
   → idx advances only on handshakes. mask_o stays stable and valid for all 5 cycles, then IDLE.
5. start_i asserted during COLLECT, and res_valid_i asserted in IDLE.
   → Both ignored, err_o = 1 and sticky. In-flight mask unaffected.
6. Reset asserted after 2 of 6 elements.
   → Outputs 0 asynchronously. A new start with vl=1 and result 1 then gives bit0 = 1 with no residue from the aborted op.
